banked_ram_dp: RTL and testbench
================================

// Module: banked_ram_dp
// PURPOSE
// - Two-port banked scratchpad RAM: the storage primitive for on-chip buffers (e.g. OBUF).
// - Port A serves the memory/DMA side; port B serves the compute-array side.
// - Each port has an independent write channel and read channel per cycle.
// - Storage is split into 2**TAG_W banks, selected by the address MSBs.
// PARAMETERS
// TAG_W       2   log2(number of banks); bank = addr[ADDR_WIDTH-1 -: TAG_W]; must be < ADDR_WIDTH
// ADDR_WIDTH  10  word address width; total depth 2**ADDR_WIDTH, bank depth 2**(ADDR_WIDTH-TAG_W)
// DATA_WIDTH  32  word width in bits
// PORTS
// clk             in   1           clock; all state updates on posedge
// reset           in   1           async active-high reset
// s_write_req_a   in   1           port A write enable
// s_write_addr_a  in   ADDR_WIDTH  port A write address
// s_write_data_a  in   DATA_WIDTH  port A write data
// s_read_req_a    in   1           port A read enable
// s_read_addr_a   in   ADDR_WIDTH  port A read address
// s_read_data_a   out  DATA_WIDTH  port A read data, registered
// s_write_req_b   in   1           port B write enable
// s_write_addr_b  in   ADDR_WIDTH  port B write address
// s_write_data_b  in   DATA_WIDTH  port B write data
// s_read_req_b    in   1           port B read enable
// s_read_addr_b   in   ADDR_WIDTH  port B read address
// s_read_data_b   out  DATA_WIDTH  port B read data, registered
// BEHAVIOUR
// - Banking: bank = addr[MSB -: TAG_W], row = remaining LSBs.
//   Each bank holds one storage array shared by both ports.
// - Write: when s_write_req_x=1 at a posedge, mem[s_write_addr_x] <= s_write_data_x.
//   No handshake and no stall.
// - Read latency is 1 cycle.
//   - A request with s_read_req_x=1 in cycle N presents mem[s_read_addr_x] on s_read_data_x after posedge N.
//   - The bank tag is registered with the request.
//   - Output data is muxed from the selected bank using the registered tag.
// - s_read_data_x holds its last value while s_read_req_x=0.
//   The tag register and data register only update on a request.
// - Read/write same address, same cycle, any port combination: read-first.
//   Read returns the old contents; the new data is visible from the next read.
// - Both ports write the same address in the same cycle: port B data wins.
//   Writes to different addresses, including the same bank, both take effect.
// - Both ports read any addresses in the same cycle: both are served, no conflict.
// - Reset (async, any time, including mid-access):
//   - s_read_data_a, s_read_data_b and the registered tags go to 0 immediately.
//   - Requests are ignored while reset=1.
//   - Memory contents are NOT cleared.
// - After reset, reading an address that was never written returns X in simulation.
//   The bench must not check such reads.
// - Address wrap: none; every address in 0..2**ADDR_WIDTH-1 is distinct.
//   The top address (all ones) is valid in the last bank.
// TESTING
// - Reset: assert reset mid-run -> both read_data outputs read 0 immediately (before the next clk edge); prior mem contents preserved after release.
// - Basic: write A addr 0x005=0xDEADBEEF; next cycle read B addr 0x005
//   -> s_read_data_b=0xDEADBEEF one cycle after the request.
//   Mirror the test B->A with 0x12345678 @0x3FF.
// - Bank sweep: write addr=k*256+7 with data k for k=0..3, read back on both ports
//   -> returns 0,1,2,3; back-to-back reads stream one per cycle.
// - Collision: A and B both write 0x010 (0xAAAA / 0xBBBB) -> read returns 0xBBBB.
//   Read 0x010 while writing 0xCCCC there -> read returns 0xBBBB, next read returns 0xCCCC.
// - Hold: read 0x005 (0xDEADBEEF), then drop read_req and write 0x005=0
//   -> s_read_data stays 0xDEADBEEF until the next read request.
// - Random: 10k cycles of random concurrent traffic on both ports vs a reference model
//   with read-first / B-wins rules -> zero mismatches.

Source files
------------

// File: rtl/banked_ram_dp.sv
// Two-port banked scratchpad RAM: independent write and read channels on each port,
// 2**TAG_W banks selected by address MSBs, 1-cycle registered reads, read-first, B wins on write collisions.
module banked_ram_dp #(
  parameter int TAG_W      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req_a,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
  input  logic [DATA_WIDTH-1:0] s_write_data_a,
  input  logic                  s_read_req_a,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
  output logic [DATA_WIDTH-1:0] s_read_data_a,
  input  logic                  s_write_req_b,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
  input  logic [DATA_WIDTH-1:0] s_write_data_b,
  input  logic                  s_read_req_b,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
  output logic [DATA_WIDTH-1:0] s_read_data_b
);

  localparam int ROW_W     = ADDR_WIDTH - TAG_W;
  localparam int NUM_BANKS = 1 << TAG_W;
  localparam int DEPTH     = 1 << ROW_W;

  logic [TAG_W-1:0]      w_wtag_a, w_wtag_b, w_rtag_a, w_rtag_b;
  logic [ROW_W-1:0]      w_wrow_a, w_wrow_b, w_rrow_a, w_rrow_b;
  logic [TAG_W-1:0]      r_tag_a, r_tag_b;
  logic [DATA_WIDTH-1:0] w_bank_data_a [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_bank_data_b [NUM_BANKS];

  assign w_wtag_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign w_wtag_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign w_rtag_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign w_rtag_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign w_wrow_a = s_write_addr_a[ROW_W-1:0];
  assign w_wrow_b = s_write_addr_b[ROW_W-1:0];
  assign w_rrow_a = s_read_addr_a[ROW_W-1:0];
  assign w_rrow_b = s_read_addr_b[ROW_W-1:0];

  // The tag picks which bank's data register drives the output; it only moves on a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_a <= '0;
      r_tag_b <= '0;
    end else begin
      if (s_read_req_a) r_tag_a <= w_rtag_a;
      if (s_read_req_b) r_tag_b <= w_rtag_b;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_a, r_data_b;

    // Contents survive reset; B's assignment comes last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
      if (!reset) begin
        if (s_write_req_a && (w_wtag_a == TAG_W'(g))) r_mem[w_wrow_a] <= s_write_data_a;
        if (s_write_req_b && (w_wtag_b == TAG_W'(g))) r_mem[w_wrow_b] <= s_write_data_b;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data_a <= '0;
        r_data_b <= '0;
      end else begin
        if (s_read_req_a && (w_rtag_a == TAG_W'(g))) r_data_a <= r_mem[w_rrow_a];
        if (s_read_req_b && (w_rtag_b == TAG_W'(g))) r_data_b <= r_mem[w_rrow_b];
      end
    end

    assign w_bank_data_a[g] = r_data_a;
    assign w_bank_data_b[g] = r_data_b;
  end

  assign s_read_data_a = w_bank_data_a[r_tag_a];
  assign s_read_data_b = w_bank_data_b[r_tag_b];

endmodule

// File: tb/tb_banked_ram_dp.sv
// Directed and model-checked random bench for banked_ram_dp:
// reset, basic cross-port transfer, bank sweep, collisions, hold and random traffic.
module tb_banked_ram_dp;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_write_req_a, s_read_req_a, s_write_req_b, s_read_req_b;
  logic [9:0]  s_write_addr_a, s_read_addr_a, s_write_addr_b, s_read_addr_b;
  logic [31:0] s_write_data_a, s_write_data_b;
  logic [31:0] s_read_data_a, s_read_data_b;

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] model [1024];
  logic [31:0] expA, expB;

  banked_ram_dp #(.TAG_W(2), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_write_req_a  (s_write_req_a),
    .s_write_addr_a (s_write_addr_a),
    .s_write_data_a (s_write_data_a),
    .s_read_req_a   (s_read_req_a),
    .s_read_addr_a  (s_read_addr_a),
    .s_read_data_a  (s_read_data_a),
    .s_write_req_b  (s_write_req_b),
    .s_write_addr_b (s_write_addr_b),
    .s_write_data_b (s_write_data_b),
    .s_read_req_b   (s_read_req_b),
    .s_read_addr_b  (s_read_addr_b),
    .s_read_data_b  (s_read_data_b)
  );

  always #5 clk = ~clk;

  // Drive one cycle of traffic, then step to just after the capturing edge.
  task automatic applyStimulus(
    input logic wrA, input logic [9:0] wAddrA, input logic [31:0] wDataA,
    input logic rdA, input logic [9:0] rAddrA,
    input logic wrB, input logic [9:0] wAddrB, input logic [31:0] wDataB,
    input logic rdB, input logic [9:0] rAddrB);
    s_write_req_a  = wrA;
    s_write_addr_a = wAddrA;
    s_write_data_a = wDataA;
    s_read_req_a   = rdA;
    s_read_addr_a  = rAddrA;
    s_write_req_b  = wrB;
    s_write_addr_b = wAddrB;
    s_write_data_b = wDataB;
    s_read_req_b   = rdB;
    s_read_addr_b  = rAddrB;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] randAddr();
    logic [1:0] bank;
    logic [7:0] row;
    bank = 2'($urandom_range(0, 3));
    row  = 8'($urandom_range(0, 15));
    return {bank, row};
  endfunction

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_a", s_read_data_a, 32'h0);
    checkOutput("reset_b", s_read_data_b, 32'h0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Cross-port transfers, including the top address.
    applyStimulus(1, 10'h005, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h005);
    checkOutput("basic_a2b", s_read_data_b, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 1, 10'h3FF, 32'h12345678, 0, 0);
    applyStimulus(0, 0, 0, 1, 10'h3FF, 0, 0, 0, 0, 0);
    checkOutput("basic_b2a", s_read_data_a, 32'h12345678);

    for (int k = 0; k < 4; k++)
      applyStimulus(1, 10'(k * 256 + 7), 32'(k), 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 1, 10'(k * 256 + 7), 0, 0, 0, 1, 10'((3 - k) * 256 + 7));
      checkOutput($sformatf("sweep_a%0d", k), s_read_data_a, 32'(k));
      checkOutput($sformatf("sweep_b%0d", k), s_read_data_b, 32'(3 - k));
    end

    // Same-address write collision, then read-first against a concurrent write.
    applyStimulus(1, 10'h010, 32'hAAAA, 0, 0, 1, 10'h010, 32'hBBBB, 0, 0);
    applyStimulus(1, 10'h010, 32'hCCCC, 1, 10'h010, 0, 0, 0, 0, 0);
    checkOutput("collide_bwins", s_read_data_a, 32'hBBBB);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h010);
    checkOutput("collide_next", s_read_data_b, 32'hCCCC);
    applyStimulus(0, 0, 0, 0, 0, 1, 10'h010, 32'hDDDD, 1, 10'h010);
    checkOutput("rdfirst_b", s_read_data_b, 32'hCCCC);

    applyStimulus(0, 0, 0, 1, 10'h005, 0, 0, 0, 0, 0);
    checkOutput("hold_read", s_read_data_a, 32'hDEADBEEF);
    applyStimulus(1, 10'h005, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_idle1", s_read_data_a, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_idle2", s_read_data_a, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 1, 10'h005, 0, 0, 0, 0, 0);
    checkOutput("hold_reread", s_read_data_a, 32'h0);

    // Mid-cycle reset clears outputs at once; requests during reset are ignored.
    applyStimulus(0, 0, 0, 1, 10'h3FF, 0, 0, 0, 1, 10'h010);
    checkOutput("pre_reset_a", s_read_data_a, 32'h12345678);
    checkOutput("pre_reset_b", s_read_data_b, 32'hDDDD);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_a", s_read_data_a, 32'h0);
    checkOutput("async_reset_b", s_read_data_b, 32'h0);
    applyStimulus(1, 10'h3FF, 32'hFFFF, 1, 10'h3FF, 1, 10'h010, 32'hEEEE, 1, 10'h010);
    checkOutput("in_reset_a", s_read_data_a, 32'h0);
    checkOutput("in_reset_b", s_read_data_b, 32'h0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 10'h3FF, 0, 0, 0, 1, 10'h010);
    checkOutput("kept_a", s_read_data_a, 32'h12345678);
    checkOutput("kept_b", s_read_data_b, 32'hDDDD);

    // Fill everything so the random phase never reads an unwritten word.
    for (int i = 0; i < 512; i++) begin
      model[i]       = 32'(i) * 32'h9E3779B1;
      model[i + 512] = 32'(i + 512) * 32'h9E3779B1;
      applyStimulus(1, 10'(i), model[i], 0, 0, 1, 10'(i + 512), model[i + 512], 0, 0);
    end
    applyStimulus(0, 0, 0, 1, 10'h000, 0, 0, 0, 1, 10'h3FF);
    expA = model[0];
    expB = model[1023];
    checkOutput("fill_a", s_read_data_a, expA);
    checkOutput("fill_b", s_read_data_b, expB);

    for (int c = 0; c < 10000; c++) begin
      logic        wa, ra, wb, rb;
      logic [9:0]  wAddrA, rAddrA, wAddrB, rAddrB;
      logic [31:0] wDataA, wDataB;
      wa = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      wAddrA = randAddr();
      rAddrA = randAddr();
      wAddrB = randAddr();
      rAddrB = randAddr();
      wDataA = $urandom;
      wDataB = $urandom;
      if (ra) expA = model[rAddrA];
      if (rb) expB = model[rAddrB];
      if (wa) model[wAddrA] = wDataA;
      if (wb) model[wAddrB] = wDataB;
      applyStimulus(wa, wAddrA, wDataA, ra, rAddrA, wb, wAddrB, wDataB, rb, rAddrB);
      checkOutput("rand_a", s_read_data_a, expA);
      checkOutput("rand_b", s_read_data_b, expB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
